// File: rtl/ad_ip_jesd204_tpl_pkg.sv
// Shared JESD204 TPL ADC capture definitions: state encoding and default length width.
// TPL_ADC_CAPTURE_SOF_ALIGN_EN adds the WAIT_SOF state to the capture FSM.
package ad_ip_jesd204_tpl_pkg;

  localparam int unsigned TPL_LENGTH_WIDTH = 16;
  localparam int unsigned TPL_STATE_WIDTH  = 3;

  localparam logic [TPL_STATE_WIDTH-1:0] TPL_ST_IDLE     = 3'd0;
  localparam logic [TPL_STATE_WIDTH-1:0] TPL_ST_ARMED    = 3'd1;
  localparam logic [TPL_STATE_WIDTH-1:0] TPL_ST_WAIT_SOF = 3'd2;
  localparam logic [TPL_STATE_WIDTH-1:0] TPL_ST_CAPTURE  = 3'd3;
  localparam logic [TPL_STATE_WIDTH-1:0] TPL_ST_DONE     = 3'd4;

  typedef enum logic [TPL_STATE_WIDTH-1:0] {
    ST_IDLE     = TPL_ST_IDLE,
    ST_ARMED    = TPL_ST_ARMED,
`ifdef TPL_ADC_CAPTURE_SOF_ALIGN_EN
    ST_WAIT_SOF = TPL_ST_WAIT_SOF,
`endif
    ST_CAPTURE  = TPL_ST_CAPTURE,
    ST_DONE     = TPL_ST_DONE
  } cap_state_e;

  // Busy covers every state between arming and completion.
  function automatic logic state_busy(input cap_state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_sof_detect.sv
// Start-of-frame detect: any octet SOF flag on a valid link beat.
module ad_ip_jesd204_tpl_adc_sof_detect #(
  parameter int unsigned OCTETS_PER_BEAT = 8
) (
  input  logic [OCTETS_PER_BEAT-1:0] link_sof_i,
  input  logic                       link_valid_i,
  output logic                       sof_o_c
);

  assign sof_o_c = link_valid_i & (|link_sof_i);

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Triggered fixed-length capture of the deframed ADC sample stream.
// Define TPL_ADC_CAPTURE_SOF_ALIGN_EN to start every capture on a frame boundary.
module ad_ip_jesd204_tpl_adc_capture_ctrl
  import ad_ip_jesd204_tpl_pkg::*;
#(
  parameter int unsigned OCTETS_PER_BEAT = 8,
  parameter int unsigned ADC_DATA_WIDTH  = 112,
  parameter int unsigned LENGTH_WIDTH    = TPL_LENGTH_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [OCTETS_PER_BEAT-1:0] link_sof,
  input  logic                       link_valid,
  input  logic [ADC_DATA_WIDTH-1:0]  adc_data_in,
  input  logic [LENGTH_WIDTH-1:0]    cfg_length,
  input  logic                       arm,
  input  logic                       trigger,
  input  logic                       abort,
  output logic [ADC_DATA_WIDTH-1:0]  adc_data_out,
  output logic                       adc_valid,
  output logic                       adc_first,
  output logic                       adc_last,
  output logic                       busy,
  output logic                       done,
  output logic                       missed_trigger
);

  cap_state_e                state_q, state_d;
  logic [LENGTH_WIDTH-1:0]   cnt_q;
  logic [LENGTH_WIDTH-1:0]   len_q;
  logic [ADC_DATA_WIDTH-1:0] data_q;
  logic                      valid_q, first_q, last_q, busy_q, done_q, missed_q;

  logic sof_c;
  logic arm_ok_c;
  logic accept_c;
  logic last_c;
  logic rearm_c;

  ad_ip_jesd204_tpl_adc_sof_detect #(
    .OCTETS_PER_BEAT (OCTETS_PER_BEAT)
  ) u_sof_detect (
    .link_sof_i   (link_sof),
    .link_valid_i (link_valid),
    .sof_o_c      (sof_c)
  );

  assign arm_ok_c = arm && (cfg_length != '0);

`ifdef TPL_ADC_CAPTURE_SOF_ALIGN_EN
  // The SOF beat that leaves WAIT_SOF is itself beat 0 of the capture.
  assign accept_c = ((state_q == ST_CAPTURE) && link_valid) ||
                    ((state_q == ST_WAIT_SOF) && sof_c);
`else
  logic unused_sof;
  assign unused_sof = sof_c;
  assign accept_c   = (state_q == ST_CAPTURE) && link_valid;
`endif

  assign last_c  = accept_c && (cnt_q == (len_q - LENGTH_WIDTH'(1)));
  assign rearm_c = (state_d == ST_ARMED) && (state_q != ST_ARMED);

  // Next state; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (arm_ok_c) state_d = ST_ARMED;
`ifdef TPL_ADC_CAPTURE_SOF_ALIGN_EN
      ST_ARMED:    if (trigger) state_d = ST_WAIT_SOF;
      ST_WAIT_SOF: if (accept_c) state_d = last_c ? ST_DONE : ST_CAPTURE;
`else
      ST_ARMED:    if (trigger) state_d = ST_CAPTURE;
`endif
      ST_CAPTURE:  if (last_c) state_d = ST_DONE;
      ST_DONE:     if (arm_ok_c) state_d = ST_ARMED;
      default:     state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_busy(state_d);
      done_q  <= (state_d == ST_DONE);
      valid_q <= accept_c;
      first_q <= accept_c && (cnt_q == '0);
      last_q  <= last_c;
      if (accept_c) data_q <= adc_data_in;
      // Count restarts whenever a new capture is armed, so CAPTURE always enters at 0.
      if (rearm_c) begin
        len_q <= cfg_length;
        cnt_q <= '0;
      end else if (accept_c) begin
        cnt_q <= cnt_q + LENGTH_WIDTH'(1);
      end
      if (arm) missed_q <= 1'b0;
      else if ((state_q == ST_IDLE) && trigger) missed_q <= 1'b1;
    end
  end

  assign adc_data_out   = data_q;
  assign adc_valid      = valid_q;
  assign adc_first      = first_q;
  assign adc_last       = last_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign missed_trigger = missed_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Directed bench for the TPL ADC capture controller; honours TPL_ADC_CAPTURE_SOF_ALIGN_EN.
module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

  localparam int unsigned OB = 8;
  localparam int unsigned DW = 112;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [OB-1:0] link_sof;
  logic          link_valid;
  logic [DW-1:0] adc_data_in;
  logic [LW-1:0] cfg_length;
  logic          arm, trigger, abort;
  logic [DW-1:0] adc_data_out;
  logic          adc_valid, adc_first, adc_last, busy, done, missed_trigger;

  int checks = 0;
  int failures = 0;

  ad_ip_jesd204_tpl_adc_capture_ctrl #(
    .OCTETS_PER_BEAT (OB),
    .ADC_DATA_WIDTH  (DW),
    .LENGTH_WIDTH    (LW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .link_sof       (link_sof),
    .link_valid     (link_valid),
    .adc_data_in    (adc_data_in),
    .cfg_length     (cfg_length),
    .arm            (arm),
    .trigger        (trigger),
    .abort          (abort),
    .adc_data_out   (adc_data_out),
    .adc_valid      (adc_valid),
    .adc_first      (adc_first),
    .adc_last       (adc_last),
    .busy           (busy),
    .done           (done),
    .missed_trigger (missed_trigger)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; link_sof = '0; link_valid = 1'b0; adc_data_in = '0;
    cfg_length = '0; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
    step(); step();
    checks++;
    if ({adc_valid, adc_first, adc_last, busy, done, missed_trigger} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000",
               {adc_valid, adc_first, adc_last, busy, done, missed_trigger});
    end
    checks++;
    if (adc_data_out !== '0) begin
      failures++; $display("FAIL reset_data got=%0h exp=0", adc_data_out);
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    link_sof = 8'h01; link_valid = 1'b1; cfg_length = 16'd4; arm = 1'b1;
    step();
    arm = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_armed_busy got=%b exp=1", busy); end
    step(); step();
    checks++;
    if (adc_valid !== 1'b0) begin failures++; $display("FAIL basic_armed_novalid got=%b exp=0", adc_valid); end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    checks++;
    if (adc_valid !== 1'b0) begin failures++; $display("FAIL basic_trig_cycle got=%b exp=0", adc_valid); end
    for (int i = 0; i < 4; i++) begin
      adc_data_in = DW'(32'hA0 + i);
      step();
      checks++;
      if ({adc_valid, adc_first, adc_last} !== {1'b1, i == 0, i == 3} || adc_data_out !== DW'(32'hA0 + i)) begin
        failures++;
        $display("FAIL basic_beat%0d got v/f/l=%b data=%0h exp v/f/l=%b data=%0h", i,
                 {adc_valid, adc_first, adc_last}, adc_data_out, {1'b1, i == 0, i == 3}, 32'hA0 + i);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_done got done=%b busy=%b exp 1 0", done, busy);
    end
    adc_data_in = DW'(32'hFF);
    step();
    checks++;
    if (adc_valid !== 1'b0 || adc_data_out !== DW'(32'hA3) || done !== 1'b1) begin
      failures++;
      $display("FAIL basic_hold got v=%b data=%0h done=%b exp 0 a3 1", adc_valid, adc_data_out, done);
    end
  endtask

  task automatic test_gaps();
    logic [4:0] pat;
    int acc;
    logic [DW-1:0] exp_data;
    pat = 5'b10101; acc = 0; exp_data = DW'(32'hA3);
    link_sof = 8'h01; link_valid = 1'b0; cfg_length = 16'd3; arm = 1'b1;
    step();
    arm = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 0; k < 5; k++) begin
      link_valid = pat[k];
      adc_data_in = DW'(32'hB0 + k);
      step();
      if (pat[k]) exp_data = DW'(32'hB0 + k);
      checks++;
      if (adc_valid !== pat[k] || adc_data_out !== exp_data || busy !== (k < 4)) begin
        failures++;
        $display("FAIL gaps_k%0d got v=%b data=%0h busy=%b exp v=%b data=%0h busy=%b", k,
                 adc_valid, adc_data_out, busy, pat[k], exp_data, k < 4);
      end
      if (pat[k]) begin
        checks++;
        if (adc_first !== (acc == 0) || adc_last !== (acc == 2)) begin
          failures++;
          $display("FAIL gaps_flags%0d got f/l=%b%b exp=%b%b", acc, adc_first, adc_last, acc == 0, acc == 2);
        end
      end
      if (adc_valid === 1'b1) acc++;
    end
    checks++;
    if (acc != 3 || done !== 1'b1) begin
      failures++; $display("FAIL gaps_count got=%0d done=%b exp=3 done=1", acc, done);
    end
  endtask

  task automatic test_len1();
    link_sof = 8'h01; link_valid = 1'b0; cfg_length = 16'd1; arm = 1'b1;
    step();
    arm = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0; link_valid = 1'b1; adc_data_in = DW'(32'hC0);
    step();
    checks++;
    if ({adc_valid, adc_first, adc_last, done} !== 4'b1111 || adc_data_out !== DW'(32'hC0)) begin
      failures++;
      $display("FAIL len1 got v/f/l/d=%b data=%0h exp 1111 c0", {adc_valid, adc_first, adc_last, done}, adc_data_out);
    end
    link_valid = 1'b0; arm = 1'b1; cfg_length = '0;
    step();
    arm = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL done_hold_len0_arm got done=%b busy=%b exp 1 0", done, busy);
    end
  endtask

`ifdef TPL_ADC_CAPTURE_SOF_ALIGN_EN
  task automatic test_sof_align();
    link_sof = '0; link_valid = 1'b0; cfg_length = 16'd2; arm = 1'b1;
    step();
    arm = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0; link_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      adc_data_in = DW'(32'hE0 + i);
      step();
      checks++;
      if (adc_valid !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL sof_wait%0d got v=%b busy=%b exp 0 1", i, adc_valid, busy);
      end
    end
    link_sof = 8'h01; adc_data_in = DW'(32'hF0);
    step();
    checks++;
    if ({adc_valid, adc_first, adc_last} !== 3'b110 || adc_data_out !== DW'(32'hF0)) begin
      failures++;
      $display("FAIL sof_first got v/f/l=%b data=%0h exp 110 f0", {adc_valid, adc_first, adc_last}, adc_data_out);
    end
    link_sof = '0; adc_data_in = DW'(32'hF1);
    step();
    checks++;
    if ({adc_valid, adc_last, done} !== 3'b111 || adc_data_out !== DW'(32'hF1)) begin
      failures++;
      $display("FAIL sof_last got v/l/d=%b data=%0h exp 111 f1", {adc_valid, adc_last, done}, adc_data_out);
    end
    link_valid = 1'b0;
  endtask
`else
  task automatic test_no_sof();
    link_sof = '0; link_valid = 1'b0; cfg_length = 16'd2; arm = 1'b1;
    step();
    arm = 1'b0; trigger = 1'b1; link_valid = 1'b1; adc_data_in = DW'(32'hD0);
    step();
    trigger = 1'b0;
    checks++;
    if (adc_valid !== 1'b0) begin failures++; $display("FAIL nosof_trig_cycle got=%b exp=0", adc_valid); end
    adc_data_in = DW'(32'hD1);
    step();
    checks++;
    if ({adc_valid, adc_first, adc_last} !== 3'b110 || adc_data_out !== DW'(32'hD1)) begin
      failures++;
      $display("FAIL nosof_first got v/f/l=%b data=%0h exp 110 d1", {adc_valid, adc_first, adc_last}, adc_data_out);
    end
    adc_data_in = DW'(32'hD2);
    step();
    checks++;
    if ({adc_valid, adc_last, done} !== 3'b111 || adc_data_out !== DW'(32'hD2)) begin
      failures++;
      $display("FAIL nosof_last got v/l/d=%b data=%0h exp 111 d2", {adc_valid, adc_last, done}, adc_data_out);
    end
    link_valid = 1'b0;
  endtask
`endif

  task automatic test_abort();
    link_sof = 8'h01; link_valid = 1'b0; cfg_length = 16'd8; arm = 1'b1;
    step();
    arm = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0; link_valid = 1'b1;
    adc_data_in = DW'(32'h10); step();
    adc_data_in = DW'(32'h11); step();
    abort = 1'b1; adc_data_in = DW'(32'h12);
    step();
    abort = 1'b0;
    checks++;
    if ({adc_valid, adc_last, busy, done} !== 4'b1000 || adc_data_out !== DW'(32'h12)) begin
      failures++;
      $display("FAIL abort_beat got v/l/b/d=%b data=%0h exp 1000 12", {adc_valid, adc_last, busy, done}, adc_data_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({adc_valid, adc_last, busy} !== 3'b000) begin
        failures++; $display("FAIL abort_idle%0d got v/l/b=%b exp 000", i, {adc_valid, adc_last, busy});
      end
    end
    link_valid = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0;
    checks++;
    if (missed_trigger !== 1'b1) begin failures++; $display("FAIL missed_set got=%b exp=1", missed_trigger); end
    step();
    checks++;
    if (missed_trigger !== 1'b1) begin failures++; $display("FAIL missed_sticky got=%b exp=1", missed_trigger); end
    arm = 1'b1; cfg_length = 16'd2;
    step();
    arm = 1'b0;
    checks++;
    if (missed_trigger !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL missed_clear got missed=%b busy=%b exp 0 1", missed_trigger, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_armed got busy=%b exp=0", busy); end
  endtask

  task automatic test_arm_trig_same();
    link_valid = 1'b0; link_sof = 8'h01; cfg_length = 16'd1; arm = 1'b1; trigger = 1'b1;
    step();
    arm = 1'b0; trigger = 1'b0; link_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (adc_valid !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL arm_trig_same%0d got v=%b busy=%b exp 0 1", i, adc_valid, busy);
      end
    end
    abort = 1'b1; link_valid = 1'b0;
    step();
    abort = 1'b0;
  endtask

  task automatic test_len0();
    cfg_length = '0; arm = 1'b1;
    step();
    arm = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL len0_arm got busy=%b done=%b exp 0 0", busy, done);
    end
    trigger = 1'b1; link_valid = 1'b1; link_sof = 8'h01;
    step();
    trigger = 1'b0;
    checks++;
    if (missed_trigger !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL len0_trig got missed=%b busy=%b exp 1 0", missed_trigger, busy);
    end
    step();
    checks++;
    if (adc_valid !== 1'b0) begin failures++; $display("FAIL len0_novalid got=%b exp=0", adc_valid); end
    link_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    cfg_length = 16'd8; arm = 1'b1; link_sof = 8'h01;
    step();
    arm = 1'b0;
    checks++;
    if (missed_trigger !== 1'b0) begin failures++; $display("FAIL rst_mid_arm_clear got=%b exp=0", missed_trigger); end
    trigger = 1'b1;
    step();
    trigger = 1'b0; link_valid = 1'b1;
    adc_data_in = DW'(32'h20); step();
    adc_data_in = DW'(32'h21); step();
    checks++;
    if (adc_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_capturing got=%b exp=1", adc_valid); end
    reset = 1'b1; adc_data_in = DW'(32'h22);
    step();
    checks++;
    if ({adc_valid, adc_first, adc_last, busy, done, missed_trigger} !== 6'b0 || adc_data_out !== '0) begin
      failures++;
      $display("FAIL rst_mid_clear got flags=%b data=%0h exp 000000 0",
               {adc_valid, adc_first, adc_last, busy, done, missed_trigger}, adc_data_out);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({adc_valid, adc_last, busy, done} !== 4'b0) begin
      failures++; $display("FAIL rst_mid_idle got v/l/b/d=%b exp 0000", {adc_valid, adc_last, busy, done});
    end
    link_valid = 1'b0;
  endtask

  task automatic test_max_len();
    int n_valid, n_first, n_last, last_idx, bad_data;
    n_valid = 0; n_first = 0; n_last = 0; last_idx = -1; bad_data = 0;
    link_sof = 8'h01; link_valid = 1'b1; cfg_length = 16'hFFFF; arm = 1'b1;
    step();
    arm = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      adc_data_in = DW'(i);
      step();
      if (adc_valid === 1'b1) begin
        n_valid++;
        if (adc_data_out !== DW'(i)) bad_data++;
      end
      if (adc_first === 1'b1) n_first++;
      if (adc_last === 1'b1) begin n_last++; last_idx = i; end
    end
    checks++;
    if (n_valid != 65535 || bad_data != 0) begin
      failures++; $display("FAIL maxlen_beats got=%0d bad_data=%0d exp=65535 0", n_valid, bad_data);
    end
    checks++;
    if (n_first != 1 || n_last != 1 || last_idx != 65534) begin
      failures++;
      $display("FAIL maxlen_flags got first=%0d last=%0d at=%0d exp 1 1 65534", n_first, n_last, last_idx);
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL maxlen_done got=%b exp=1", done); end
    link_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_len1();
`ifdef TPL_ADC_CAPTURE_SOF_ALIGN_EN
    test_sof_align();
`else
    test_no_sof();
`endif
    test_abort();
    test_arm_trig_same();
    test_len0();
    test_reset_mid();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
